// File: rtl/line_buffer_bram_if.sv
// rtl/line_buffer_bram_if.sv - pixel stream in / pixel column out bundle for line_buffer_bram
interface line_buffer_bram_if #(
  parameter int DATA_W    = 8,
  parameter int LINE_W    = 640,
  parameter int NUM_LINES = 3
);
  localparam int ADDR_W = $clog2(LINE_W);

  logic                        in_valid_i;
  logic                        in_sof_i;
  logic [DATA_W-1:0]           in_data_i;
  logic                        out_valid_o;
  logic [NUM_LINES*DATA_W-1:0] out_col_o;
  logic [ADDR_W-1:0]           out_col_idx_o;
  logic                        out_eol_o;
  logic                        out_window_valid_o;

  modport master (
    output in_valid_i, in_sof_i, in_data_i,
    input  out_valid_o, out_col_o, out_col_idx_o, out_eol_o, out_window_valid_o
  );

  modport slave (
    input  in_valid_i, in_sof_i, in_data_i,
    output out_valid_o, out_col_o, out_col_idx_o, out_eol_o, out_window_valid_o
  );
endinterface

// File: rtl/line_buffer_bram.sv
// rtl/line_buffer_bram.sv - NUM_LINES-bank circular line buffer emitting one pixel column per input pixel
// LINE_BUFFER_BRAM_OUT_REG_EN adds a second output register stage (latency 2 instead of 1).
module line_buffer_bram #(
  parameter int  DATA_W    = 8,
  parameter int  LINE_W    = 640,
  parameter int  NUM_LINES = 3,
  localparam int ADDR_W    = $clog2(LINE_W)
) (
  input logic               clk,
  input logic               rst,
  line_buffer_bram_if.slave bus
);
  localparam int BANK_W = $clog2(NUM_LINES);

  logic [DATA_W-1:0] mem [NUM_LINES][LINE_W];

  logic [ADDR_W-1:0] col_q, col_eff;
  logic [BANK_W-1:0] bank_q, bank_eff;
  logic [BANK_W-1:0] seen_q, seen_eff;
  logic              accept;
  logic              last_col;
  logic [BANK_W-1:0] rd_bank [NUM_LINES];

  logic                        s1_valid;
  logic [NUM_LINES*DATA_W-1:0] s1_col;
  logic [ADDR_W-1:0]           s1_idx;
  logic                        s1_eol;
  logic                        s1_win;

  assign accept = bus.in_valid_i;

  // SOF restarts the frame before this pixel is processed.
  always_comb begin
    col_eff  = bus.in_sof_i ? '0 : col_q;
    bank_eff = bus.in_sof_i ? '0 : bank_q;
    seen_eff = bus.in_sof_i ? '0 : seen_q;
    last_col = (col_eff == ADDR_W'(LINE_W - 1));
    for (int k = 0; k < NUM_LINES; k++) begin
      rd_bank[k] = BANK_W'((int'(bank_eff) + NUM_LINES - k) % NUM_LINES);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      mem[bank_eff][col_eff] <= bus.in_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q    <= '0;
      bank_q   <= '0;
      seen_q   <= '0;
      s1_valid <= 1'b0;
      s1_col   <= '0;
      s1_idx   <= '0;
      s1_eol   <= 1'b0;
      s1_win   <= 1'b0;
    end else begin
      s1_valid <= accept;
      s1_eol   <= accept && last_col;
      s1_win   <= accept && (seen_eff == BANK_W'(NUM_LINES - 1));
      if (accept) begin
        s1_idx             <= col_eff;
        s1_col[DATA_W-1:0] <= bus.in_data_i;
        // Lanes older than the lines seen so far hold stale RAM data; blank them.
        for (int k = 1; k < NUM_LINES; k++) begin
          s1_col[k*DATA_W +: DATA_W] <= (k <= int'(seen_eff)) ? mem[rd_bank[k]][col_eff] : '0;
        end
        if (last_col) begin
          col_q  <= '0;
          bank_q <= (bank_eff == BANK_W'(NUM_LINES - 1)) ? '0 : bank_eff + BANK_W'(1);
          seen_q <= (seen_eff == BANK_W'(NUM_LINES - 1)) ? seen_eff : seen_eff + BANK_W'(1);
        end else begin
          col_q  <= col_eff + ADDR_W'(1);
          bank_q <= bank_eff;
          seen_q <= seen_eff;
        end
      end
    end
  end

`ifdef LINE_BUFFER_BRAM_OUT_REG_EN
  logic                        s2_valid;
  logic [NUM_LINES*DATA_W-1:0] s2_col;
  logic [ADDR_W-1:0]           s2_idx;
  logic                        s2_eol;
  logic                        s2_win;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_col   <= '0;
      s2_idx   <= '0;
      s2_eol   <= 1'b0;
      s2_win   <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_col   <= s1_col;
      s2_idx   <= s1_idx;
      s2_eol   <= s1_eol;
      s2_win   <= s1_win;
    end
  end

  assign bus.out_valid_o        = s2_valid;
  assign bus.out_col_o          = s2_col;
  assign bus.out_col_idx_o      = s2_idx;
  assign bus.out_eol_o          = s2_eol;
  assign bus.out_window_valid_o = s2_win;
`else
  assign bus.out_valid_o        = s1_valid;
  assign bus.out_col_o          = s1_col;
  assign bus.out_col_idx_o      = s1_idx;
  assign bus.out_eol_o          = s1_eol;
  assign bus.out_window_valid_o = s1_win;
`endif
endmodule

// File: tb/tb_line_buffer_bram.sv
// tb/tb_line_buffer_bram.sv - table-driven bench for line_buffer_bram (LINE_W=4 and LINE_W=5, NUM_LINES=3)
module tb_line_buffer_bram;
`ifdef LINE_BUFFER_BRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_buffer_bram_if #(.DATA_W(8), .LINE_W(4), .NUM_LINES(3)) bus ();
  line_buffer_bram_if #(.DATA_W(8), .LINE_W(5), .NUM_LINES(3)) bus5 ();

  line_buffer_bram #(.DATA_W(8), .LINE_W(4), .NUM_LINES(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  line_buffer_bram #(.DATA_W(8), .LINE_W(5), .NUM_LINES(3)) dut5 (
    .clk (clk),
    .rst (rst),
    .bus (bus5)
  );

  typedef struct {
    logic        rst;
    logic        vld;
    logic        sof;
    logic [7:0]  din;
    logic        e_vld;
    logic [23:0] e_col;
    logic [1:0]  e_idx;
    logic        e_eol;
    logic        e_win;
    logic        chk_all;
  } vec_t;

  vec_t vecs[$];
  vec_t pipe [2];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   b_row    = 0;
  int   b_col    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] lane(input int row, input int col, input int k);
    return (row >= k) ? 8'(16 * (row - k) + col) : 8'h00;
  endfunction

  task automatic add_pix(input logic sof);
    vec_t v;
    if (sof) begin
      b_row = 0;
      b_col = 0;
    end
    v.rst     = 1'b0;
    v.vld     = 1'b1;
    v.sof     = sof;
    v.din     = 8'(16 * b_row + b_col);
    v.e_vld   = 1'b1;
    v.e_col   = {lane(b_row, b_col, 2), lane(b_row, b_col, 1), v.din};
    v.e_idx   = 2'(b_col);
    v.e_eol   = (b_col == 3);
    v.e_win   = (b_row >= 2);
    v.chk_all = 1'b0;
    vecs.push_back(v);
    b_col++;
    if (b_col == 4) begin
      b_col = 0;
      b_row++;
    end
  endtask

  // SOF is asserted during gaps on purpose: without valid it must be ignored.
  task automatic add_gap();
    vec_t v;
    v = '{rst: 1'b0, vld: 1'b0, sof: 1'b1, din: 8'hEE, e_vld: 1'b0, e_col: 24'h0,
          e_idx: 2'd0, e_eol: 1'b0, e_win: 1'b0, chk_all: 1'b0};
    vecs.push_back(v);
  endtask

  task automatic add_rst(input logic vld);
    vec_t v;
    v = '{rst: 1'b1, vld: vld, sof: 1'b0, din: 8'hAA, e_vld: 1'b0, e_col: 24'h0,
          e_idx: 2'd0, e_eol: 1'b0, e_win: 1'b0, chk_all: 1'b1};
    vecs.push_back(v);
    b_row = 0;
    b_col = 0;
  endtask

  task automatic check_out(input vec_t e);
    chk("out_valid", 32'(bus.out_valid_o), 32'(e.e_vld));
    chk("out_window_valid", 32'(bus.out_window_valid_o), 32'(e.e_win));
    if (e.e_vld || e.chk_all) begin
      chk("out_col", 32'(bus.out_col_o), 32'(e.e_col));
      chk("out_col_idx", 32'(bus.out_col_idx_o), 32'(e.e_idx));
      chk("out_eol", 32'(bus.out_eol_o), 32'(e.e_eol));
    end
  endtask

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.in_sof_i    = 1'b0;
    bus.in_data_i   = 8'h00;
    bus5.in_valid_i = 1'b0;
    bus5.in_sof_i   = 1'b0;
    bus5.in_data_i  = 8'h00;

    // reset state, then lines 0..3 back to back (line 3 reuses bank 0)
    add_rst(1'b0);
    add_rst(1'b0);
    add_pix(1'b1);
    for (int i = 1; i < 16; i++) add_pix(1'b0);
    add_gap();
    add_gap();
    // lines 0..2 with 1-on / 2-off valid pattern
    add_rst(1'b0);
    for (int i = 0; i < 12; i++) begin
      add_pix(i == 0);
      add_gap();
      add_gap();
    end
    // SOF two pixels into line 1, then two more full lines
    add_rst(1'b0);
    for (int i = 0; i < 6; i++) add_pix(i == 0);
    add_pix(1'b1);
    for (int i = 0; i < 11; i++) add_pix(1'b0);
    // reset mid-line with a pixel presented alongside it; the next pixel restarts at col 0
    add_pix(1'b0);
    add_pix(1'b0);
    add_rst(1'b1);
    for (int i = 0; i < 5; i++) add_pix(1'b0);
    add_gap();
    add_gap();

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst           = vecs[i].rst;
      bus.in_valid_i = vecs[i].vld;
      bus.in_sof_i   = vecs[i].sof;
      bus.in_data_i  = vecs[i].din;
      @(posedge clk);
      #1;
      cyc = i;
      if (vecs[i].rst) begin
        for (int p = 0; p < LAT; p++) pipe[p] = vecs[i];
      end else begin
        for (int p = LAT - 1; p > 0; p--) pipe[p] = pipe[p-1];
        pipe[0] = vecs[i];
      end
      check_out(pipe[LAT-1]);
    end

    // LINE_W=5: column index must wrap 4 -> 0 and switch banks
    @(negedge clk);
    rst            = 1'b1;
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7 + LAT - 1; i++) begin
      if (i > 0) @(negedge clk);
      bus5.in_valid_i = (i < 7);
      bus5.in_sof_i   = (i == 0);
      bus5.in_data_i  = (i < 5) ? 8'(i) : 8'(16 + i - 5);
      @(posedge clk);
      #1;
      cyc = 1000 + i;
      if (i - (LAT - 1) >= 0) begin
        automatic int j = i - (LAT - 1);
        automatic logic [23:0] exp_col;
        if (j < 5) exp_col = 24'(j);
        else if (j == 5) exp_col = 24'h000010;
        else exp_col = 24'h000111;
        chk("w5_valid", 32'(bus5.out_valid_o), 32'd1);
        chk("w5_idx", 32'(bus5.out_col_idx_o), 32'(j % 5));
        chk("w5_eol", 32'(bus5.out_eol_o), 32'(j == 4));
        chk("w5_col", 32'(bus5.out_col_o), 32'(exp_col));
        chk("w5_window", 32'(bus5.out_window_valid_o), 32'd0);
      end
    end
    @(negedge clk);
    bus5.in_valid_i = 1'b0;
    bus5.in_sof_i   = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
